// File: rtl/mem_req_pkg.sv
// Shared types and default widths for the memory requester.
package mem_req_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_LEN_W     = 4;
    localparam int DEF_RSP_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous FIFO buffering read beats; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define
    // which entries are valid, and the output is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_requester.sv
// Command-driven memory requester: single-beat writes and flow-controlled
// burst reads into a small response FIFO.
module mem_requester
    import mem_req_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int BEAT_W = LEN_W + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata;
    logic [BEAT_W-1:0] beats_left;
    logic              is_last;
    logic              in_flight;
    logic              in_flight_last;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W:0]   fifo_out;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W:0]    limit;

    // A beat may issue only if its data is guaranteed a slot when it lands.
    assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(in_flight);
    assign limit     = (CNT_W + 1)'(RSP_DEPTH) + (CNT_W + 1)'(pop);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and a latch is never inferred.
    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        mem_write_en = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = rst_n;
                if (cmd_valid && rst_n) state_next = cmd_write ? WRITE : READ;
            end
            WRITE: begin
                mem_write_en = 1'b1;
                state_next   = IDLE;
            end
            READ: begin
                if (occupancy < limit) begin
                    issue = 1'b1;
                    if (is_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr           <= '0;
            addr_hold      <= '0;
            wdata          <= '0;
            beats_left     <= '0;
            is_last        <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= issue && is_last;
            if (accept) begin
                addr       <= cmd_addr;
                wdata      <= cmd_wdata;
                beats_left <= BEAT_W'(cmd_len) + BEAT_W'(1);
                is_last    <= (cmd_len == '0);
            end
            if (state == WRITE) addr_hold <= addr;
            if (issue) begin
                addr_hold  <= addr;
                addr       <= addr + ADDR_W'(1);
                beats_left <= beats_left - BEAT_W'(1);
                is_last    <= (beats_left == BEAT_W'(2));
            end
        end
    end

    // Idle shows the last address actually presented, not the post-increment one.
    assign mem_address    = (state == IDLE) ? addr_hold : addr;
    assign mem_write_data = wdata;

    rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_data ({in_flight_last, mem_read_data}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = fifo_out[DATA_W-1:0];
    assign rsp_last  = fifo_out[DATA_W];
    assign busy      = (state != IDLE) || in_flight || !fifo_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_flight && fifo_full && !pop));

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester with a registered memory model and a
// response scoreboard.
module tb_mem_requester;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic [7:0] mem_address;
    logic       mem_write_en;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] wdata;
        logic [7:0] exp_first;
    } vec_t;

    vec_t       vecs [7];
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [8:0] sb_q [$];
    int         checks = 0;
    int         errors = 0;
    logic       stalled_prev = 1'b0;
    logic [8:0] held = '0;
    logic [7:0] addr6;

    mem_requester #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .LEN_W     (4),
        .RSP_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_last       (rsp_last),
        .busy           (busy),
        .mem_address    (mem_address),
        .mem_write_en   (mem_write_en),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer and hold-stability monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev)
                check("rsp_hold", 32'({rsp_valid, rsp_last, rsp_data}), 32'({1'b1, held}));
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_beat: got 0x%0h with nothing expected", rsp_data);
                end else begin
                    logic [8:0] exp;
                    exp = sb_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
                    check("rsp_last", 32'(rsp_last), 32'(exp[8]));
                end
            end
            stalled_prev = rsp_valid && !rsp_ready;
            held         = {rsp_last, rsp_data};
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [3:0] l,
                        input logic [7:0] d, input logic use_first, input logic [7:0] first);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_wdata = d;
        if (w) begin
            ref_mem[a] = d;
        end else begin
            for (int b = 0; b <= int'(l); b++) begin
                logic [7:0] ia;
                logic [7:0] dv;
                ia = a + 8'(b);
                dv = (b == 0 && use_first) ? first : ref_mem[ia];
                sb_q.push_back({(b == int'(l)), dv});
            end
        end
        while (!cmd_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_handshake: cmd_ready still 0 after %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d beats outstanding, busy=%0b", sb_q.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        vecs[0] = '{1'b1, 8'h10, 4'd0, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 8'h10, 4'd0, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 8'h20, 4'd0, 8'h3C, 8'h00};
        vecs[3] = '{1'b0, 8'h20, 4'd0, 8'h00, 8'h3C};
        vecs[4] = '{1'b1, 8'h31, 4'd0, 8'h77, 8'h00};
        vecs[5] = '{1'b0, 8'h30, 4'd2, 8'h00, 8'h53};
        vecs[6] = '{1'b0, 8'hFE, 4'd3, 8'h00, 8'hF5};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last",  32'(rsp_last), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_wr_en",     32'(mem_write_en), 32'd0);
        check("rst_address",   32'(mem_address), 32'd0);
        check("rst_wr_data",   32'(mem_write_data), 32'd0);
        check("rst_rsp_data",  32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].write, vecs[i].addr, vecs[i].len, vecs[i].wdata, 1'b1, vecs[i].exp_first);
            if (vecs[i].write) begin
                @(negedge clk);
                check("wr_en",   32'(mem_write_en), 32'd1);
                check("wr_addr", 32'(mem_address), 32'(vecs[i].addr));
                check("wr_data", 32'(mem_write_data), 32'(vecs[i].wdata));
                @(posedge clk);
                #1;
                check("wr_ready_next", 32'(cmd_ready), 32'd1);
                check("wr_en_off",     32'(mem_write_en), 32'd0);
            end else begin
                @(negedge clk);
                check("rd_addr",      32'(mem_address), 32'(vecs[i].addr));
                check("rd_wr_en_off", 32'(mem_write_en), 32'd0);
                check("rd_not_ready", 32'(cmd_ready), 32'd0);
                @(negedge clk);
                check("rd_early_valid", 32'(rsp_valid), 32'd0);
                for (int b = 0; b <= int'(vecs[i].len); b++) begin
                    @(negedge clk);
                    check("rd_beat_valid", 32'(rsp_valid), 32'd1);
                end
                wait_drain();
            end
        end

        // 16-beat burst with the consumer stalled for five cycles.
        send(1'b0, 8'h40, 4'd15, 8'h00, 1'b0, 8'h00);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 6) addr6 = mem_address;
            if (c == 9) begin
                check("stall_addr", 32'(mem_address), 32'(addr6));
                check("stall_busy", 32'(busy), 32'd1);
                check("stall_valid", 32'(rsp_valid), 32'd1);
            end
            if (c == 4) begin
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
            end
            if (c == 9) begin
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        end
        wait_drain();

        // Reset in the middle of a burst.
        send(1'b0, 8'h80, 4'd15, 8'h00, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check("mid_burst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_gates_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy",      32'(busy), 32'd0);
        check("midrst_address",   32'(mem_address), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("release_ready", 32'(cmd_ready), 32'd1);
        check("release_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Memory contents survive the reset.
        send(1'b0, 8'h10, 4'd0, 8'h00, 1'b1, 8'hA5);
        wait_drain();
        send(1'b0, 8'h20, 4'd1, 8'h00, 1'b1, 8'h3C);
        wait_drain();

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, default 8, memory address width; DATA_W, default 8, memory data width; LEN_W, default 4, burst length field width; RSP_DEPTH, default 2, response buffer entries.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: host command valid.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 The block SHALL have port cmd_write, input, 1 bit: 1 = single-beat write, 0 = burst read.
REQ-007 The block SHALL have port cmd_addr, input, ADDR_W bits: start address.
REQ-008 The block SHALL have port cmd_len, input, LEN_W bits: read beats minus 1 (1..16 beats); ignored for writes.
REQ-009 The block SHALL have port cmd_wdata, input, DATA_W bits: write data.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: read data beat valid.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: host accepts the beat.
REQ-012 The block SHALL have port rsp_data, output, DATA_W bits: read data beat.
REQ-013 The block SHALL have port rsp_last, output, 1 bit: final beat of a burst.
REQ-014 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE, a read is in flight, or the buffer is non-empty.
REQ-015 The block SHALL have port mem_address, output, ADDR_W bits: memory address.
REQ-016 The block SHALL have port mem_write_en, output, 1 bit: memory write strobe.
REQ-017 The block SHALL have port mem_write_data, output, DATA_W bits: memory write data.
REQ-018 The block SHALL have port mem_read_data, input, DATA_W bits: memory read data, registered in the memory, valid 1 cycle after the address is presented.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, WRITE and READ.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a handshake occurs when cmd_valid && cmd_ready.
REQ-021 On a handshake, the block SHALL register addr, wdata, the beat count (cmd_len+1) and a last-beat tracker, then go to WRITE if cmd_write=1, else to READ.
REQ-022 In WRITE (1 cycle), the block SHALL drive mem_write_en=1, mem_address=addr and mem_write_data=wdata, then go to IDLE; write handshake at T gives the strobe at T+1 and cmd_ready=1 at T+2.
REQ-023 In READ, the block SHALL issue one beat per cycle (mem_address=addr, mem_write_en=0) when count + in_flight - pop < RSP_DEPTH, where pop = rsp_valid && rsp_ready; otherwise it SHALL hold the address and stall.
REQ-024 Each issued read beat SHALL set an in_flight flag; on the next cycle the block SHALL push mem_read_data into the buffer, tagged with last if it was the final beat.
REQ-025 After each issue, addr SHALL increment modulo 2^ADDR_W (0xFF wraps to 0x00).
REQ-026 After the final beat is issued, the FSM SHALL go to IDLE; the in-flight beat is still captured, and a new command may be accepted in the same cycle the capture occurs.
REQ-027 Read latency SHALL be: handshake at T gives rsp_valid at T+3; with rsp_ready held at 1, beats follow on consecutive cycles.
REQ-028 The response buffer SHALL be FIFO-ordered with no loss or duplication; rsp_data and rsp_last SHALL stay stable while rsp_valid && !rsp_ready.
REQ-029 A simultaneous push and pop with the buffer full SHALL be legal; the issue rule SHALL guarantee that a push never finds the buffer full without a pop in that cycle.
REQ-030 When not in WRITE, mem_write_en SHALL be 0; mem_address SHALL hold its last value when idle.

Reset
REQ-031 While rst_n=0 at posedge clk, the block SHALL enter IDLE, clear in_flight, and empty the buffer.
REQ-032 While rst_n=0, outputs SHALL be: cmd_ready=0, rsp_valid=0, rsp_last=0, busy=0, mem_write_en=0, mem_address=0, mem_write_data=0, rsp_data=0.
REQ-033 A reset mid-burst SHALL discard all pending and in-flight beats; memory contents are not touched.

Structure
REQ-034 Package mem_req_pkg SHALL hold the state enum (IDLE, WRITE, READ) and the default width constants.
REQ-035 The buffer SHALL be the sub-module rsp_fifo (parameterized depth and width, push/pop/full/empty/count).

Verification
REQ-036 Scenario: write 0x10<=0xA5, then read len=0 at 0x10 -> mem_write_en 1 cycle, rsp_data=0xA5, rsp_last=1 at handshake+3.
REQ-037 Scenario: read len=3 at 0xFE, rsp_ready=1 -> beats from FE, FF, 00, 01 on 4 consecutive cycles, rsp_last on the 4th only.
REQ-038 Scenario: read len=15, rsp_ready=0 for cycles 5-9 -> all 16 beats in order, no duplication, buffer never exceeds 2, mem_address stalls.
REQ-039 Scenario: rst_n low mid-burst -> rsp_valid=0 and busy=0 next cycle; cmd_ready=1 in the first cycle after release.
REQ-040 Scenario: write 0x20<=0x3C immediately followed by read 0x20 -> rsp_data=0x3C.
